// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
// -----------------------------------------------------------------------------
// Parametrised UART transmitter. Accepts one word per valid/ready handshake,
// latches it into a shadow shift register and serialises it as
//     start(0) | DATA_W data bits, LSB first | optional parity | stop bit(s)(1)
// with every serial bit held for CLKS_PER_BIT clock cycles.
//
// Parameters:
//   DATA_W        data bits per frame (5..9)
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   PARITY        0 = none, 1 = even, 2 = odd, 3 = none
//   STOP_BITS     1 or 2; any other value gives 1
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   asynchronous active-low reset
//   tx_valid  in   producer presents a word on tx_data
//   tx_data   in   word to send (DATA_W bits)
//   tx_ready  out  block can accept a word (decode of state == IDLE)
//   tx        out  registered serial line, idle high
//   busy      out  registered, high while a frame is in progress
//   done      out  registered one-cycle pulse when the last stop bit ends
// -----------------------------------------------------------------------------
module uart_tx_frame #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_W);

    // PARITY values other than 1/2 fall back to "no parity bit"
    localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
    localparam bit PAR_ODD = (PARITY == 2);

    // Only an explicit 2 gives two stop bits
    localparam int STOP_N = (STOP_BITS == 2) ? 2 : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_N - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // Parity helper: even parity is the XOR of all bits, odd is its inverse
    // -------------------------------------------------------------------------
    function automatic logic calc_parity(input logic [DATA_W-1:0] word,
                                         input logic              odd);
        return (^word) ^ odd;
    endfunction

    // -------------------------------------------------------------------------
    // Registers and next-state wires
    // -------------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_next;
    logic [BAUD_W-1:0]   r_baud;
    logic [BAUD_W-1:0]   w_baud_next;
    logic [BIT_W-1:0]    r_bit;
    logic [BIT_W-1:0]    w_bit_next;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_next;
    logic                r_parity;
    logic                w_parity_next;
    logic                r_tx;
    logic                w_tx_next;
    logic                r_busy;
    logic                w_busy_next;
    logic                r_done;
    logic                w_done_next;

    logic                w_accept;
    logic                w_baud_last;

    assign w_accept    = (r_state == S_IDLE) && tx_valid;
    assign w_baud_last = (r_baud == BAUD_LAST);

    // State register plus all datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_baud   <= w_baud_next;
            r_bit    <= w_bit_next;
            r_shift  <= w_shift_next;
            r_parity <= w_parity_next;
            r_tx     <= w_tx_next;
            r_busy   <= w_busy_next;
            r_done   <= w_done_next;
        end
    end

    // Next-state decode: each non-idle state lasts whole bit periods
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (tx_valid) begin
                    w_state_next = S_START;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_START: begin
                if (w_baud_last) begin
                    w_state_next = S_DATA;
                end else begin
                    w_state_next = S_START;
                end
            end
            S_DATA: begin
                if (w_baud_last && (r_bit == DATA_LAST)) begin
                    w_state_next = PAR_EN ? S_PARITY : S_STOP;
                end else begin
                    w_state_next = S_DATA;
                end
            end
            S_PARITY: begin
                if (w_baud_last) begin
                    w_state_next = S_STOP;
                end else begin
                    w_state_next = S_PARITY;
                end
            end
            S_STOP: begin
                if (w_baud_last && (r_bit == STOP_LAST)) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_STOP;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Baud/bit counters, shadow shift register and captured parity
    always_comb begin
        w_baud_next   = r_baud;
        w_bit_next    = r_bit;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;

        // Baud counter parks at zero in IDLE so START gets a full bit period
        if ((r_state == S_IDLE) || w_baud_last) begin
            w_baud_next = '0;
        end else begin
            w_baud_next = r_baud + BAUD_W'(1);
        end

        // Bit counter restarts on every state change, advances per bit period
        if (w_state_next != r_state) begin
            w_bit_next = '0;
        end else if (w_baud_last) begin
            w_bit_next = r_bit + BIT_W'(1);
        end else begin
            w_bit_next = r_bit;
        end

        // The word and its parity are frozen at acceptance; later tx_data
        // changes cannot reach the line
        if (w_accept) begin
            w_shift_next  = tx_data;
            w_parity_next = calc_parity(tx_data, PAR_ODD);
        end else if ((r_state == S_DATA) && w_baud_last) begin
            w_shift_next  = {1'b0, r_shift[DATA_W-1:1]};
            w_parity_next = r_parity;
        end else begin
            w_shift_next  = r_shift;
            w_parity_next = r_parity;
        end
    end

    // Output decode: registered outputs are computed from the state being
    // entered, so tx already shows the start bit after the accepting edge
    always_comb begin
        w_tx_next   = 1'b1;
        w_busy_next = (w_state_next != S_IDLE);
        w_done_next = (r_state == S_STOP) && (w_state_next == S_IDLE);
        case (w_state_next)
            S_IDLE:   w_tx_next = 1'b1;
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
            S_PARITY: w_tx_next = r_parity;
            S_STOP:   w_tx_next = 1'b1;
            default:  w_tx_next = 1'b1;
        endcase
    end

    assign tx_ready = (r_state == S_IDLE);
    assign tx       = r_tx;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for uart_tx_frame. Three instances cover the
// configurations of interest:
//   u_a : DATA_W=8, CLKS_PER_BIT=4, even parity, 1 stop  (F = 44)
//   u_b : DATA_W=8, CLKS_PER_BIT=4, odd parity,  1 stop  (F = 44)
//   u_c : DATA_W=7, CLKS_PER_BIT=4, no parity,   2 stops (F = 40)
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame;

    logic clk = 1'b0;
    logic rst;

    logic       v_a, v_b, v_c;
    logic [7:0] d_a, d_b;
    logic [6:0] d_c;
    logic       rdy_a, tx_a, busy_a, done_a;
    logic       rdy_b, tx_b, busy_b, done_b;
    logic       rdy_c, tx_c, busy_c, done_c;

    int checks   = 0;
    int failures = 0;

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst), .tx_valid(v_a), .tx_data(d_a),
        .tx_ready(rdy_a), .tx(tx_a), .busy(busy_a), .done(done_a));

    uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u_b (
        .clk(clk), .rst(rst), .tx_valid(v_b), .tx_data(d_b),
        .tx_ready(rdy_b), .tx(tx_b), .busy(busy_b), .done(done_b));

    uart_tx_frame #(.DATA_W(7), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) u_c (
        .clk(clk), .rst(rst), .tx_valid(v_c), .tx_data(d_c),
        .tx_ready(rdy_c), .tx(tx_c), .busy(busy_c), .done(done_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // {tx, tx_ready, busy, done} of the selected instance
    function automatic logic [3:0] outs(input int id);
        case (id)
            0:       return {tx_a, rdy_a, busy_a, done_a};
            1:       return {tx_b, rdy_b, busy_b, done_b};
            default: return {tx_c, rdy_c, busy_c, done_c};
        endcase
    endfunction

    task automatic set_in(input int id, input logic v, input logic [8:0] w);
        case (id)
            0: begin v_a = v; d_a = w[7:0]; end
            1: begin v_b = v; d_b = w[7:0]; end
            default: begin v_c = v; d_c = w[6:0]; end
        endcase
    endtask

    // Sends one word starting from a falling edge with the instance idle and
    // checks every cycle of the frame, the done cycle and (unless the next
    // word is chained) the idle cycle after it. par_bit and flen are the
    // hand-computed parity bit and frame length.
    task automatic frame(input int id, input string nm, input logic [8:0] word,
                         input int dw, input bit has_par, input logic par_bit,
                         input int nstop, input int flen,
                         input bit hold, input logic [8:0] nxt);
        logic exp_bits [16];
        int   k;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < dw; i++) exp_bits[1 + i] = word[i];
        k = 1 + dw;
        if (has_par) begin
            exp_bits[k] = par_bit;
            k++;
        end
        for (int i = 0; i < nstop; i++) begin
            exp_bits[k] = 1'b1;
            k++;
        end
        set_in(id, 1'b1, word);
        @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < flen; c++) begin
            chk($sformatf("%s_c%0d", nm, c), {28'd0, outs(id)},
                {28'd0, exp_bits[c / 4], 1'b0, 1'b1, 1'b0});
            if ((c == 0) && !hold) set_in(id, 1'b0, word);
            // Scramble tx_data mid-frame; the shadow copy must be unaffected
            if (c == 9) set_in(id, hold, 9'h1FF);
            @(negedge clk);
        end
        chk($sformatf("%s_done", nm), {28'd0, outs(id)}, 32'h0000_000D);
        if (hold) begin
            set_in(id, 1'b1, nxt);
        end else begin
            @(negedge clk);
            chk($sformatf("%s_idle", nm), {28'd0, outs(id)}, 32'h0000_000C);
        end
    endtask

    initial begin
        // Reset asserted from time 0 with valid high on every instance
        rst = 1'b0;
        set_in(0, 1'b1, 9'h0A5);
        set_in(1, 1'b1, 9'h000);
        set_in(2, 1'b1, 9'h07F);
        repeat (3) @(negedge clk);
        chk("rst_a", {28'd0, outs(0)}, 32'h0000_000C);
        chk("rst_b", {28'd0, outs(1)}, 32'h0000_000C);
        chk("rst_c", {28'd0, outs(2)}, 32'h0000_000C);
        repeat (4) @(negedge clk);
        chk("rst_hold_a", {28'd0, outs(0)}, 32'h0000_000C);
        set_in(0, 1'b0, 9'h000);
        set_in(1, 1'b0, 9'h000);
        set_in(2, 1'b0, 9'h000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_a", {28'd0, outs(0)}, 32'h0000_000C);
        chk("post_rst_b", {28'd0, outs(1)}, 32'h0000_000C);
        chk("post_rst_c", {28'd0, outs(2)}, 32'h0000_000C);

        // Even parity 0xA5: 0,1,0,1,0,0,1,0,1,P=0,1
        frame(0, "a_A5", 9'h0A5, 8, 1'b1, 1'b0, 1, 44, 1'b0, 9'h000);
        // Odd parity: 0x00 -> 1, 0xFF -> 1
        frame(1, "b_00", 9'h000, 8, 1'b1, 1'b1, 1, 44, 1'b0, 9'h000);
        frame(1, "b_FF", 9'h0FF, 8, 1'b1, 1'b1, 1, 44, 1'b0, 9'h000);
        // 7 data bits, no parity, two stop bits
        frame(2, "c_7F", 9'h07F, 7, 1'b0, 1'b0, 2, 40, 1'b0, 9'h000);
        // Back-to-back with valid held: second start bit one cycle after done
        frame(0, "a_55", 9'h055, 8, 1'b1, 1'b0, 1, 44, 1'b1, 9'h00F);
        frame(0, "a_0F", 9'h00F, 8, 1'b1, 1'b0, 1, 44, 1'b0, 9'h000);

        // Reset during data bit 3 of 0xA5 (frame cycle 17)
        set_in(0, 1'b1, 9'h0A5);
        @(posedge clk);
        @(negedge clk);
        set_in(0, 1'b0, 9'h0A5);
        repeat (17) @(negedge clk);
        chk("mid_pre", {28'd0, outs(0)}, 32'h0000_0002);
        rst = 1'b0;
        #1;
        chk("mid_rst", {28'd0, outs(0)}, 32'h0000_000C);
        set_in(0, 1'b1, 9'h0A5);
        repeat (3) @(negedge clk);
        chk("mid_rst_hold", {28'd0, outs(0)}, 32'h0000_000C);
        set_in(0, 1'b0, 9'h0A5);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_release", {28'd0, outs(0)}, 32'h0000_000C);
        // Even parity 0x3C (four ones) -> 0
        frame(0, "a_3C", 9'h03C, 8, 1'b1, 1'b0, 1, 44, 1'b0, 9'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
